// File: rtl/riscv_fetch_queue.sv
// W-wide in-order instruction fetch queue between the I-memory response path and decode.
// Accepts and presents up to W lanes per cycle, supports a redirect flush and a sticky error flag.
module riscv_fetch_queue #(
    parameter int W     = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    localparam int CW   = $clog2(W + 1),
    localparam int QW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     enq_cnt,
    input  logic [W*XLEN-1:0] enq_inst,
    input  logic [W*XLEN-1:0] enq_pc,
    output logic              enq_rdy,
    output logic [CW-1:0]     deq_cnt,
    output logic [W*XLEN-1:0] deq_inst,
    output logic [W*XLEN-1:0] deq_pc,
    input  logic [CW-1:0]     deq_take,
    input  logic              flush,
    output logic [QW-1:0]     count,
    output logic              err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [QW-1:0] W_Q     = QW'(W);
    localparam logic [QW-1:0] DEPTH_Q = QW'(DEPTH);
    localparam logic [CW-1:0] W_C     = CW'(W);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [QW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [CW-1:0] eff_enq;
    logic [CW-1:0] eff_take;
    logic [W-1:0]  wr_en;
    logic [AW-1:0] wr_idx [W];
    logic [AW-1:0] rd_idx [W];

    assign enq_rdy = (DEPTH_Q - count_q) >= W_Q;
    assign deq_cnt = (count_q < W_Q) ? CW'(count_q) : W_C;
    assign count   = count_q;
    assign err     = err_q;

    always_comb begin
        eff_enq  = '0;
        eff_take = '0;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q;

        if (enq_rdy) begin
            eff_enq = (enq_cnt > W_C) ? W_C : enq_cnt;
        end
        eff_take = (deq_take > deq_cnt) ? deq_cnt : deq_take;

        // Protocol checks stay live during flush cycles too.
        if ((enq_cnt != '0 && !enq_rdy) || (enq_cnt > W_C) || (deq_take > deq_cnt)) begin
            err_d = 1'b1;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(eff_take);
            tail_d  = tail_q + AW'(eff_enq);
            count_d = count_q + QW'(eff_enq) - QW'(eff_take);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Lane i maps to ring slot (ptr + i); pointer wrap keeps lane order across DEPTH-1 -> 0.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        assign wr_idx[gi] = tail_q + AW'(gi);
        assign rd_idx[gi] = head_q + AW'(gi);
        assign wr_en[gi]  = !reset && !flush && (CW'(gi) < eff_enq);
        assign deq_inst[gi*XLEN +: XLEN] = (CW'(gi) < deq_cnt) ? inst_mem[rd_idx[gi]] : '0;
        assign deq_pc[gi*XLEN +: XLEN]   = (CW'(gi) < deq_cnt) ? pc_mem[rd_idx[gi]]   : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (wr_en[i]) begin
                inst_mem[wr_idx[i]] <= enq_inst[i*XLEN +: XLEN];
                pc_mem[wr_idx[i]]   <= enq_pc[i*XLEN +: XLEN];
            end
        end
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: hand-derived vector table, wrap and corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_riscv_fetch_queue;
    localparam int W     = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(W + 1);
    localparam int QW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     enq_cnt;
    logic [W*XLEN-1:0] enq_inst;
    logic [W*XLEN-1:0] enq_pc;
    logic              enq_rdy;
    logic [CW-1:0]     deq_cnt;
    logic [W*XLEN-1:0] deq_inst;
    logic [W*XLEN-1:0] deq_pc;
    logic [CW-1:0]     deq_take;
    logic              flush;
    logic [QW-1:0]     count;
    logic              err;

    riscv_fetch_queue #(.W(W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .enq_cnt(enq_cnt), .enq_inst(enq_inst), .enq_pc(enq_pc),
        .enq_rdy(enq_rdy), .deq_cnt(deq_cnt), .deq_inst(deq_inst), .deq_pc(deq_pc),
        .deq_take(deq_take), .flush(flush), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          fl;
        int          ec;
        int          take;
        logic [31:0] pcb;
        int          e_count;
        int          e_dc;
        bit          e_rdy;
        bit          e_err;
        logic [31:0] e_pc0;
    } vec_t;

    vec_t tbl [$];
    int tests = 0;
    int fails = 0;

    // Reference model: the queue contents in program order plus the sticky error bit.
    logic [31:0] q_pc [$];
    logic [31:0] q_inst [$];
    bit          m_err;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h00100093 + ((pc - 32'h200) >> 2) * 32'h00100080;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit fl, input int ec, input int take,
                              input logic [31:0] pcb);
        int sz, dc, n;
        bit rdy;
        sz  = q_pc.size();
        rdy = (DEPTH - sz) >= W;
        dc  = (sz < W) ? sz : W;
        if (rst) begin
            q_pc.delete();
            q_inst.delete();
            m_err = 0;
            return;
        end
        if ((ec > 0 && !rdy) || ec > W || take > dc) m_err = 1;
        if (fl) begin
            q_pc.delete();
            q_inst.delete();
            return;
        end
        n = (take < dc) ? take : dc;
        repeat (n) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
        end
        n = rdy ? ((ec < W) ? ec : W) : 0;
        for (int i = 0; i < n; i++) begin
            q_pc.push_back(pcb + 32'(4 * i));
            q_inst.push_back(inst_of(pcb + 32'(4 * i)));
        end
    endtask

    task automatic check_model();
        int sz, dc;
        logic [31:0] ep, ei;
        sz = q_pc.size();
        dc = (sz < W) ? sz : W;
        chk("m_count", 32'(count), 32'(sz));
        chk("m_deq_cnt", 32'(deq_cnt), 32'(dc));
        chk("m_enq_rdy", 32'(enq_rdy), 32'((DEPTH - sz) >= W));
        chk("m_err", 32'(err), 32'(m_err));
        for (int i = 0; i < W; i++) begin
            ep = (i < dc) ? q_pc[i] : 32'h0;
            ei = (i < dc) ? q_inst[i] : 32'h0;
            chk($sformatf("m_pc_lane%0d", i), deq_pc[i*XLEN +: XLEN], ep);
            chk($sformatf("m_inst_lane%0d", i), deq_inst[i*XLEN +: XLEN], ei);
        end
    endtask

    task automatic apply(input bit rst, input bit fl, input int ec, input int take,
                         input logic [31:0] pcb);
        reset    = rst;
        flush    = fl;
        enq_cnt  = CW'(ec);
        deq_take = CW'(take);
        for (int i = 0; i < W; i++) begin
            enq_pc[i*XLEN +: XLEN]   = pcb + 32'(4 * i);
            enq_inst[i*XLEN +: XLEN] = inst_of(pcb + 32'(4 * i));
        end
        model_step(rst, fl, ec, take, pcb);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic add(input bit rst, input bit fl, input int ec, input int take,
                       input logic [31:0] pcb, input int e_count, input int e_dc,
                       input bit e_rdy, input bit e_err, input logic [31:0] e_pc0);
        vec_t v;
        v.rst = rst; v.fl = fl; v.ec = ec; v.take = take; v.pcb = pcb;
        v.e_count = e_count; v.e_dc = e_dc; v.e_rdy = e_rdy; v.e_err = e_err; v.e_pc0 = e_pc0;
        tbl.push_back(v);
    endtask

    task automatic run_row(input int idx);
        vec_t v;
        v = tbl[idx];
        apply(v.rst, v.fl, v.ec, v.take, v.pcb);
        chk($sformatf("row%0d_count", idx), 32'(count), 32'(v.e_count));
        chk($sformatf("row%0d_deq_cnt", idx), 32'(deq_cnt), 32'(v.e_dc));
        chk($sformatf("row%0d_enq_rdy", idx), 32'(enq_rdy), 32'(v.e_rdy));
        chk($sformatf("row%0d_err", idx), 32'(err), 32'(v.e_err));
        chk($sformatf("row%0d_pc0", idx), deq_pc[XLEN-1:0], v.e_pc0);
    endtask

    initial begin
        int split, dc, ec, tk;
        bit fl, rs;
        logic [31:0] wpc, rpc;

        reset = 1'b1; flush = 1'b0; enq_cnt = '0; deq_take = '0; enq_inst = '0; enq_pc = '0;
        m_err = 0;

        //   rst fl ec tk pcbase     cnt dc rdy err pc0
        add(1, 0, 0, 0, 32'h0,   0, 0, 1, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,   0, 0, 1, 0, 32'h0);
        add(0, 0, 2, 0, 32'h200, 2, 2, 1, 0, 32'h200);
        add(0, 0, 0, 1, 32'h0,   1, 1, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h208, 2, 2, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h20c, 3, 2, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h210, 4, 2, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h214, 5, 2, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h218, 6, 2, 1, 0, 32'h204);
        add(0, 0, 1, 0, 32'h21c, 7, 2, 0, 0, 32'h204);
        add(0, 0, 2, 0, 32'h300, 7, 2, 0, 1, 32'h204);  // offered while not ready
        add(0, 0, 0, 2, 32'h0,   5, 2, 1, 1, 32'h20c);
        add(0, 0, 0, 2, 32'h0,   3, 2, 1, 1, 32'h214);
        add(0, 0, 0, 1, 32'h0,   2, 2, 1, 1, 32'h218);  // head now at slot 6
        split = tbl.size();
        add(0, 0, 2, 0, 32'h2c0, 4, 2, 1, 1, 32'h2b8);
        add(0, 0, 1, 0, 32'h2c8, 5, 2, 1, 1, 32'h2b8);
        add(0, 1, 2, 2, 32'h400, 0, 0, 1, 1, 32'h0);    // flush beats enq/deq
        add(0, 0, 2, 0, 32'h500, 2, 2, 1, 1, 32'h500);
        add(0, 0, 2, 0, 32'h508, 4, 2, 1, 1, 32'h500);
        add(1, 0, 2, 2, 32'h700, 0, 0, 1, 0, 32'h0);    // reset beats everything
        add(0, 0, 0, 1, 32'h0,   0, 0, 1, 1, 32'h0);    // take from empty
        add(1, 0, 0, 0, 32'h0,   0, 0, 1, 0, 32'h0);
        add(0, 0, 3, 0, 32'h600, 2, 2, 1, 1, 32'h600);  // enq_cnt > W
        add(1, 0, 0, 0, 32'h0,   0, 0, 1, 0, 32'h0);

        for (int i = 0; i < split; i++) run_row(i);

        // Steady enq 2 / take 2 starting at head slot 6, across the ring wrap.
        wpc = 32'h220;
        for (int k = 0; k < 20; k++) begin
            apply(0, 0, 2, 2, wpc);
            chk($sformatf("wrap%0d_count", k), 32'(count), 32'd2);
            chk($sformatf("wrap%0d_pc0", k), deq_pc[XLEN-1:0], 32'h220 + 32'(8 * k));
            chk($sformatf("wrap%0d_pc1", k), deq_pc[2*XLEN-1:XLEN], 32'h224 + 32'(8 * k));
            wpc += 32'h8;
        end

        for (int i = split; i < tbl.size(); i++) run_row(i);

        // Random traffic, mostly legal, with occasional protocol violations, flushes and resets.
        rpc = 32'h1000;
        for (int n = 0; n < 400; n++) begin
            dc = (q_pc.size() < W) ? q_pc.size() : W;
            ec = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, W));
            tk = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, dc));
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 49) == 0);
            apply(rs, fl, ec, tk, rpc);
            rpc += 32'h10;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
